// File: rtl/tour_pkg.sv
// tour_pkg: shared constants, city coordinate table and FSM state type
// for the tour fitness evaluator.
package tour_pkg;

  localparam int N_GENES = 30;
  localparam int GENE_W  = 5;
  localparam int COORD_W = 8;
  localparam int FIT_W   = 16;
  localparam int CHROM_W = N_GENES * GENE_W;
  localparam int IDX_W   = $clog2(N_GENES + 1);

  localparam logic [GENE_W-1:0] GENE_LIMIT = GENE_W'(N_GENES);

  typedef logic [COORD_W-1:0] coord_t;

  // Default layout pending survey data: cities on a line, 8 apart.
  localparam coord_t CITY_X [0:31] = '{
    8'd0,   8'd8,   8'd16,  8'd24,  8'd32,  8'd40,  8'd48,  8'd56,
    8'd64,  8'd72,  8'd80,  8'd88,  8'd96,  8'd104, 8'd112, 8'd120,
    8'd128, 8'd136, 8'd144, 8'd152, 8'd160, 8'd168, 8'd176, 8'd184,
    8'd192, 8'd200, 8'd208, 8'd216, 8'd224, 8'd232, 8'd0,   8'd0
  };

  localparam coord_t CITY_Y [0:31] = '{32{8'd0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/tour_fitness_if.sv
// tour_fitness_if: start/done handshake plus chromosome in, fitness out.
interface tour_fitness_if;
  import tour_pkg::*;

  logic               start;
  logic [CHROM_W-1:0] chromosome;
  logic [FIT_W-1:0]   fitness;
  logic               invalid;
  logic               busy;
  logic               done;

  modport master (
    output start, chromosome,
    input  fitness, invalid, busy, done
  );

  modport slave (
    input  start, chromosome,
    output fitness, invalid, busy, done
  );

endinterface

// File: rtl/tour_fitness_city_lut.sv
// city_lut: combinational gene -> (x,y) lookup; genes past the last city
// read as the origin and raise oob.
module city_lut
  import tour_pkg::*;
(
  input  logic [GENE_W-1:0] gene,
  output coord_t            x,
  output coord_t            y,
  output logic              oob
);

  // Table read with an out-of-range override to (0,0).
  always_comb begin
    oob = (gene >= GENE_LIMIT);
    x   = '0;
    y   = '0;
    if (!oob) begin
      x = CITY_X[gene];
      y = CITY_Y[gene];
    end
  end

endmodule

// File: rtl/tour_fitness.sv
// tour_fitness: accumulates the closed-tour Manhattan length of a
// chromosome, one edge per clock, and flags illegal tours.
// Optional duplicate-gene detection: define TOUR_FITNESS_DUP_CHECK_EN.
module tour_fitness
  import tour_pkg::*;
(
  input logic           clk,
  input logic           rst,
  tour_fitness_if.slave bus
);

  state_t             state, state_next;
  logic [CHROM_W-1:0] chrom_q;
  logic [IDX_W-1:0]   idx;
  logic [FIT_W-1:0]   acc;
  logic               err;
  logic [FIT_W-1:0]   fitness_q;
  logic               invalid_q, busy_q, done_q;

  logic               accept, finish, last_edge;
  logic [IDX_W-1:0]   prev_pos, cur_pos;
  logic [GENE_W-1:0]  prev_gene, cur_gene;
  coord_t             prev_x, prev_y, cur_x, cur_y, dx, dy;
  logic               prev_oob, cur_oob, dup_hit;
  logic [8:0]         edge_len;

  assign last_edge = (idx == IDX_W'(N_GENES));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and the one-cycle accept/finish strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE:    if (bus.start) begin
                 accept     = 1'b1;
                 state_next = ACCUM;
               end
      ACCUM:   if (last_edge) state_next = DONE;
      DONE:    begin
                 finish     = 1'b1;
                 state_next = IDLE;
               end
      default: state_next = IDLE;
    endcase
  end

  // Edge endpoints: g[idx-1] -> g[idx], wrapping to g[0] on the closing edge.
  always_comb begin
    prev_pos = '0;
    cur_pos  = '0;
    if (idx != '0) begin
      prev_pos = idx - 1'b1;
      if (!last_edge) cur_pos = idx;
    end
    prev_gene = chrom_q[prev_pos*GENE_W +: GENE_W];
    cur_gene  = chrom_q[cur_pos*GENE_W +: GENE_W];
  end

  city_lut u_prev_lut (.gene(prev_gene), .x(prev_x), .y(prev_y), .oob(prev_oob));
  city_lut u_cur_lut  (.gene(cur_gene),  .x(cur_x),  .y(cur_y),  .oob(cur_oob));

  // Per-axis absolute differences summed into a 9-bit edge length.
  always_comb begin
    dx       = (prev_x > cur_x) ? prev_x - cur_x : cur_x - prev_x;
    dy       = (prev_y > cur_y) ? prev_y - cur_y : cur_y - prev_y;
    edge_len = {1'b0, dx} + {1'b0, dy};
  end

`ifdef TOUR_FITNESS_DUP_CHECK_EN
  logic [31:0] seen, seen_base, seen_next;

  // g[0] joins the mask on the first edge; each newly visited gene is
  // tested against everything marked before it.
  always_comb begin
    seen_base = seen;
    if (idx == IDX_W'(1)) seen_base[prev_gene] = 1'b1;
    seen_next = seen_base;
    seen_next[cur_gene] = 1'b1;
    dup_hit = (state == ACCUM) && !last_edge && seen_base[cur_gene];
  end

  // Seen-mask register, cleared whenever a new chromosome is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              seen <= '0;
    else if (accept)                      seen <= '0;
    else if (state == ACCUM && !last_edge) seen <= seen_next;
  end
`else
  assign dup_hit = 1'b0;
`endif

  // Datapath: capture, accumulate per edge, then publish the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chrom_q   <= '0;
      idx       <= '0;
      acc       <= '0;
      err       <= 1'b0;
      fitness_q <= '0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        chrom_q <= bus.chromosome;
        idx     <= IDX_W'(1);
        acc     <= '0;
        err     <= 1'b0;
        busy_q  <= 1'b1;
      end else if (state == ACCUM) begin
        acc <= acc + FIT_W'(edge_len);
        if (prev_oob || cur_oob || dup_hit) err <= 1'b1;
        if (!last_edge) idx <= idx + 1'b1;
      end
      if (finish) begin
        fitness_q <= err ? '1 : acc;
        invalid_q <= err;
        done_q    <= 1'b1;
        busy_q    <= 1'b0;
      end
    end
  end

  assign bus.fitness = fitness_q;
  assign bus.invalid = invalid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_tour_fitness.sv
// tb_tour_fitness: directed and randomized tours checked against a
// closed-loop tour-length model built from the city layout.
module tb_tour_fitness;
  import tour_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  tour_fitness_if bus ();

  tour_fitness dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  function automatic int cityX(input int g);
    return (g < N_GENES) ? 8 * g : 0;
  endfunction

  function automatic int cityY(input int g);
    return (g < N_GENES) ? 0 * g : 0;
  endfunction

  // Reference: sum of Manhattan hops around the closed tour.
  function automatic void model(input logic [CHROM_W-1:0] c, output int fit, output int inv);
    int g [N_GENES];
    int cnt [32];
    int sum, nxt, ddx, ddy;
    inv = 0;
    sum = 0;
    foreach (cnt[i]) cnt[i] = 0;
    for (int k = 0; k < N_GENES; k++) begin
      g[k] = int'(c[GENE_W*k +: GENE_W]);
      if (g[k] >= N_GENES) inv = 1;
      cnt[g[k]]++;
    end
`ifdef TOUR_FITNESS_DUP_CHECK_EN
    foreach (cnt[i]) if (cnt[i] > 1) inv = 1;
`endif
    for (int k = 0; k < N_GENES; k++) begin
      nxt = g[(k + 1) % N_GENES];
      ddx = cityX(g[k]) - cityX(nxt);
      ddy = cityY(g[k]) - cityY(nxt);
      sum += (ddx < 0 ? -ddx : ddx) + (ddy < 0 ? -ddy : ddy);
    end
    fit = inv ? 32'hFFFF : sum;
  endfunction

  function automatic logic [CHROM_W-1:0] pack(input int genes [N_GENES]);
    logic [CHROM_W-1:0] c;
    int v;
    c = '0;
    for (int k = 0; k < N_GENES; k++) begin
      v = genes[k];
      c[GENE_W*k +: GENE_W] = v[GENE_W-1:0];
    end
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present a chromosome for one accepting edge, then scramble the bus.
  task automatic applyStimulus(input logic [CHROM_W-1:0] c);
    bus.start      = 1'b1;
    bus.chromosome = c;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.chromosome = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic waitDone(input int already, output int lat);
    lat = -1;
    for (int c = already + 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic checkResult(input string tag, input logic [CHROM_W-1:0] c, input int lat);
    int fit, inv;
    model(c, fit, inv);
    checkOutput({tag, " latency"}, lat, 31);
    checkOutput({tag, " fitness"}, bus.fitness, fit);
    checkOutput({tag, " invalid"}, bus.invalid, inv);
    checkOutput({tag, " busy@done"}, bus.busy, 0);
  endtask

  task automatic runTour(input string tag, input logic [CHROM_W-1:0] c);
    int lat;
    applyStimulus(c);
    checkOutput({tag, " busy"}, bus.busy, 1);
    waitDone(0, lat);
    checkResult(tag, c, lat);
    @(posedge clk); #1;
    checkOutput({tag, " done pulse"}, bus.done, 0);
  endtask

  initial begin
    int genes [N_GENES];
    int lat, done_seen, j, t;
    logic [CHROM_W-1:0] c1, c2;

    rst = 1'b0;
    bus.start = 1'b0;
    bus.chromosome = '0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checkOutput("reset fitness", bus.fitness, 0);
    checkOutput("reset invalid", bus.invalid, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset done", bus.done, 0);
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("start in reset", bus.busy, 0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (genes[k]) genes[k] = k;
    runTour("identity", pack(genes));

    genes[5] = 10; genes[10] = 5;
    runTour("swap5_10", pack(genes));

    foreach (genes[k]) genes[k] = k;
    genes[7] = 31;
    runTour("gene31", pack(genes));

    foreach (genes[k]) genes[k] = k;
    genes[4] = 3;
    runTour("dup3", pack(genes));

    // Second start mid-run must be dropped.
    foreach (genes[k]) genes[k] = k;
    c1 = pack(genes);
    genes[0] = 12; genes[12] = 0;
    c2 = pack(genes);
    applyStimulus(c1);
    repeat (9) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.chromosome = c2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    waitDone(10, lat);
    checkResult("restart ignored", c1, lat);
    @(posedge clk); #1;

    // Reset mid-evaluation: no done, outputs cleared at once.
    applyStimulus(c2);
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midreset busy", bus.busy, 0);
    checkOutput("midreset fitness", bus.fitness, 0);
    @(posedge clk); #6;
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    checkOutput("midreset no done", done_seen, 0);
    runTour("after reset", c2);

    // Random legal permutations.
    for (int r = 0; r < 6; r++) begin
      foreach (genes[k]) genes[k] = k;
      for (int k = N_GENES - 1; k > 0; k--) begin
        j = $urandom_range(k, 0);
        t = genes[k]; genes[k] = genes[j]; genes[j] = t;
      end
      runTour($sformatf("perm%0d", r), pack(genes));
    end

    // Random in-range genes (duplicates likely) and fully random genes.
    for (int r = 0; r < 3; r++) begin
      foreach (genes[k]) genes[k] = $urandom_range(N_GENES - 1, 0);
      runTour($sformatf("dupr%0d", r), pack(genes));
      foreach (genes[k]) genes[k] = $urandom_range(31, 0);
      runTour($sformatf("anyr%0d", r), pack(genes));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
